// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: synchronises and deglitches the PS/2 lines, frames
// start/data/parity/stop bits, guards each frame with a watchdog and folds the
// E0 (extended) and F0 (break) prefixes into flags on a single key event.
module ps2_keyboard_rx #(
  parameter int FILT_LEN    = 8,
  parameter int TIMEOUT_CYC = 100000,
  parameter int PARITY_EN   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_brk,
  output logic       key_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int FW = $clog2(FILT_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t        state, next_state;
  logic [1:0]    clk_sync, dat_sync;
  logic          clk_s, dat_s;
  logic [FW-1:0] filt_cnt;
  logic          filt_clk, filt_clk_d;
  logic          strobe;
  logic [TW-1:0] wd_cnt;
  logic          timeout;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          par_bit;
  logic          ext_flag, brk_flag;
  logic          eval;
  logic          frame_bad;

  assign clk_s = clk_sync[1];
  assign dat_s = dat_sync[1];

  // Two-flop synchronisers for both raw pins; idle level of the bus is high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_dat};
    end
  end

  // Deglitch filter: the filtered clock only follows after FILT_LEN consecutive
  // samples disagree with it; any agreeing sample restarts the count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      filt_cnt   <= '0;
      filt_clk   <= 1'b1;
      filt_clk_d <= 1'b1;
    end else begin
      filt_clk_d <= filt_clk;
      if (clk_s == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILT_LEN)) begin
        filt_clk <= clk_s;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  assign strobe    = filt_clk_d & ~filt_clk;
  assign timeout   = (state != IDLE) && !strobe && (wd_cnt == TW'(TIMEOUT_CYC - 1));
  assign frame_bad = !dat_s || ((PARITY_EN != 0) && !(^{shift, par_bit}));

  // Watchdog counts cycles between strobes while a frame is in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_cnt <= '0;
    end else if (state == IDLE || strobe || timeout) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  // Frame state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // Next-state logic: advances on strobes only; a strobe overrides the timeout.
  always_comb begin
    next_state = state;
    if (strobe) begin
      case (state)
        IDLE:    if (!dat_s) next_state = DATA;
        DATA:    if (bit_cnt == 3'd7) next_state = PARITY;
        PARITY:  next_state = STOP;
        STOP:    next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end else if (timeout) begin
      next_state = IDLE;
    end
  end

  // FSM-derived outputs: busy level and the stop-bit evaluation strobe.
  always_comb begin
    busy = (state != IDLE);
    eval = strobe && (state == STOP);
  end

  // Bit capture: data shifts in LSB first, parity bit stored separately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt <= '0;
      shift   <= '0;
      par_bit <= 1'b0;
    end else if (strobe) begin
      case (state)
        IDLE:    bit_cnt <= '0;
        DATA: begin
          shift   <= {dat_s, shift[7:1]};
          bit_cnt <= bit_cnt + 1'b1;
        end
        PARITY:  par_bit <= dat_s;
        default: ;
      endcase
    end
  end

  // Frame evaluation, prefix tracking and the registered key event outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_code  <= '0;
      key_ext   <= 1'b0;
      key_brk   <= 1'b0;
      key_valid <= 1'b0;
      frame_err <= 1'b0;
      ext_flag  <= 1'b0;
      brk_flag  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      frame_err <= 1'b0;
      if (eval) begin
        if (frame_bad) begin
          frame_err <= 1'b1;
          ext_flag  <= 1'b0;
          brk_flag  <= 1'b0;
        end else begin
          case (shift)
            8'hE0: ext_flag <= 1'b1;
            8'hF0: brk_flag <= 1'b1;
            8'h00, 8'hFF: begin
              ext_flag <= 1'b0;
              brk_flag <= 1'b0;
            end
            default: begin
              key_code  <= shift;
              key_ext   <= ext_flag;
              key_brk   <= brk_flag;
              key_valid <= 1'b1;
              ext_flag  <= 1'b0;
              brk_flag  <= 1'b0;
            end
          endcase
        end
      end else if (timeout) begin
        frame_err <= 1'b1;
        ext_flag  <= 1'b0;
        brk_flag  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed testbench for ps2_keyboard_rx: frames are bit-banged on scaled-down
// PS/2 timing and key events are checked against hand-computed values.
`timescale 1ns/1ps
module tb_ps2_keyboard_rx;

  localparam int FILT_LEN    = 8;
  localparam int TIMEOUT_CYC = 500;
  localparam int HALF        = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic [7:0] key_code, np_code;
  logic       key_ext, key_brk, key_valid, frame_err, busy;
  logic       np_ext, np_brk, np_valid, np_err, np_busy;

  int errors = 0;
  int checks = 0;
  int kv_cnt = 0, fe_cnt = 0, both_cnt = 0, np_kv_cnt = 0;
  int last_lat = 0;
  int kv0, fe0, np0;
  bit seen;

  ps2_keyboard_rx #(.FILT_LEN(FILT_LEN), .TIMEOUT_CYC(TIMEOUT_CYC), .PARITY_EN(1)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
    .key_code(key_code), .key_ext(key_ext), .key_brk(key_brk),
    .key_valid(key_valid), .frame_err(frame_err), .busy(busy)
  );

  ps2_keyboard_rx #(.FILT_LEN(FILT_LEN), .TIMEOUT_CYC(TIMEOUT_CYC), .PARITY_EN(0)) dut_np (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
    .key_code(np_code), .key_ext(np_ext), .key_brk(np_brk),
    .key_valid(np_valid), .frame_err(np_err), .busy(np_busy)
  );

  // 50 MHz system clock.
  always #10 clk = ~clk;

  // Pulse counters, sampled on the inactive edge.
  always @(negedge clk) begin
    if (key_valid) kv_cnt++;
    if (frame_err) fe_cnt++;
    if (key_valid && frame_err) both_cnt++;
    if (np_valid) np_kv_cnt++;
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One PS/2 bit: data set up while the clock is high, then a low phase during
  // which the key_valid latency from the falling edge is recorded.
  task automatic ps2_bit(input logic b);
    @(negedge clk);
    ps2_dat = b;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    for (int i = 1; i <= HALF; i++) begin
      @(posedge clk);
      #1;
      if (key_valid && last_lat == 0) last_lat = i;
    end
    @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic clk_glitch();
    repeat (10) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (FILT_LEN - 1) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic apply_stimulus(input logic [7:0] d, input logic bad_par,
                                input int nbits, input int glitch_at);
    logic [10:0] f;
    f = {1'b1, (~^d) ^ bad_par, d, 1'b0};
    last_lat = 0;
    for (int i = 0; i < nbits; i++) begin
      ps2_bit(f[i]);
      if (i == glitch_at) clk_glitch();
    end
    repeat (5) @(negedge clk);
  endtask

  initial begin
    // Reset state
    #1;
    check_output("rst_code", {24'd0, key_code}, 32'h00);
    check_output("rst_flags", {28'd0, key_ext, key_brk, key_valid, frame_err}, 32'h0);
    check_output("rst_busy", {31'd0, busy}, 32'h0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // Short low glitch while idle must not start a frame
    clk_glitch();
    check_output("idle_glitch_busy", {31'd0, busy}, 32'h0);

    // Plain make code 1C with latency measurement
    kv0 = kv_cnt; fe0 = fe_cnt;
    apply_stimulus(8'h1C, 1'b0, 11, -1);
    check_output("1c_latency", last_lat, FILT_LEN + 4);
    check_output("1c_code", {24'd0, key_code}, 32'h1C);
    check_output("1c_ext_brk", {30'd0, key_ext, key_brk}, 32'h0);
    check_output("1c_pulses", kv_cnt - kv0, 1);
    check_output("1c_no_err", fe_cnt - fe0, 0);
    check_output("1c_busy", {31'd0, busy}, 32'h0);

    // Break: F0 then 1C
    kv0 = kv_cnt;
    apply_stimulus(8'hF0, 1'b0, 11, -1);
    check_output("f0_no_pulse", kv_cnt - kv0, 0);
    apply_stimulus(8'h1C, 1'b0, 11, -1);
    check_output("brk_pulse", kv_cnt - kv0, 1);
    check_output("brk_code", {24'd0, key_code}, 32'h1C);
    check_output("brk_ext_brk", {30'd0, key_ext, key_brk}, 32'h1);

    // Extended break: E0 F0 75, then plain 29
    kv0 = kv_cnt;
    apply_stimulus(8'hE0, 1'b0, 11, -1);
    apply_stimulus(8'hF0, 1'b0, 11, -1);
    apply_stimulus(8'h75, 1'b0, 11, -1);
    check_output("ext_pulse", kv_cnt - kv0, 1);
    check_output("ext_code", {24'd0, key_code}, 32'h75);
    check_output("ext_ext_brk", {30'd0, key_ext, key_brk}, 32'h3);
    apply_stimulus(8'h29, 1'b0, 11, -1);
    check_output("plain29_code", {24'd0, key_code}, 32'h29);
    check_output("plain29_ext_brk", {30'd0, key_ext, key_brk}, 32'h0);

    // Overrun byte 00 discards pending prefix
    kv0 = kv_cnt;
    apply_stimulus(8'hF0, 1'b0, 11, -1);
    apply_stimulus(8'h00, 1'b0, 11, -1);
    check_output("overrun_no_pulse", kv_cnt - kv0, 0);
    apply_stimulus(8'h1C, 1'b0, 11, -1);
    check_output("overrun_brk_cleared", {30'd0, key_ext, key_brk}, 32'h0);

    // Bad parity: error with parity checking, accepted without it
    apply_stimulus(8'h29, 1'b0, 11, -1);
    kv0 = kv_cnt; fe0 = fe_cnt; np0 = np_kv_cnt;
    apply_stimulus(8'h1C, 1'b1, 11, -1);
    check_output("par_err_pulse", fe_cnt - fe0, 1);
    check_output("par_no_valid", kv_cnt - kv0, 0);
    check_output("par_code_held", {24'd0, key_code}, 32'h29);
    check_output("nopar_valid", np_kv_cnt - np0, 1);
    check_output("nopar_code", {24'd0, np_code}, 32'h1C);

    // Glitch in the middle of a frame
    kv0 = kv_cnt; fe0 = fe_cnt;
    apply_stimulus(8'h5A, 1'b0, 11, 4);
    check_output("glitch_code", {24'd0, key_code}, 32'h5A);
    check_output("glitch_pulse", kv_cnt - kv0, 1);
    check_output("glitch_no_err", fe_cnt - fe0, 0);

    // Timeout after a partial frame, with a pending F0 that must be dropped
    apply_stimulus(8'hF0, 1'b0, 11, -1);
    fe0 = fe_cnt;
    apply_stimulus(8'h00, 1'b0, 4, -1);
    check_output("partial_busy", {31'd0, busy}, 32'h1);
    seen = 1'b0;
    for (int i = 0; i < 4 * TIMEOUT_CYC && !seen; i++) begin
      @(negedge clk);
      if (fe_cnt != fe0) seen = 1'b1;
    end
    check_output("timeout_seen", {31'd0, seen}, 32'h1);
    repeat (2) @(negedge clk);
    check_output("timeout_err_count", fe_cnt - fe0, 1);
    check_output("timeout_busy", {31'd0, busy}, 32'h0);
    apply_stimulus(8'h29, 1'b0, 11, -1);
    check_output("after_to_code", {24'd0, key_code}, 32'h29);
    check_output("after_to_ext_brk", {30'd0, key_ext, key_brk}, 32'h0);

    // Asynchronous reset in the middle of a frame
    apply_stimulus(8'h00, 1'b0, 3, -1);
    check_output("pre_rst_busy", {31'd0, busy}, 32'h1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_output("midrst_code", {24'd0, key_code}, 32'h00);
    check_output("midrst_flags", {28'd0, key_ext, key_brk, key_valid, frame_err}, 32'h0);
    check_output("midrst_busy", {31'd0, busy}, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    kv0 = kv_cnt;
    apply_stimulus(8'h1C, 1'b0, 11, -1);
    check_output("post_rst_code", {24'd0, key_code}, 32'h1C);
    check_output("post_rst_pulse", kv_cnt - kv0, 1);

    check_output("never_both", both_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
